// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD digit constants and the digit clamp helper
// for the decade down counter.
package bcd_down_counter_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [3:0] BCD_ZERO = 4'd0;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// One BCD decade of the down counter: clamp on load,
// decrement with 0 -> 9 wrap.
module bcd_down_digit
   import bcd_down_counter_pkg::*;
(
   input  logic       clock,
   input  logic       clear_in,
   input  logic       load,
   input  logic [3:0] ld_val,
   input  logic       dec_en,
   output logic [3:0] q,
   output logic       is_zero
);

   logic [3:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (load)
         q_d = bcd_clamp(ld_val);
      else if (dec_en)
         q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
   end

   always_ff @(posedge clock) begin
      if (clear_in)
         q_q <= BCD_ZERO;
      else
         q_q <= q_d;
   end

   assign q       = q_q;
   assign is_zero = (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Synchronous multi-digit BCD down counter with load and terminal count.
// Define BCD_DOWN_AUTO_RELOAD_EN to reload the last loaded value at zero.
module bcd_down_counter
   import bcd_down_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 2
) (
   input  logic                        clock,
   input  logic                        clear_in,
   input  logic                        enable,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
   output logic [BCD_W*NUM_DIGITS-1:0] count,
   output logic                        zero,
   output logic                        tc
);

   localparam int W = BCD_W * NUM_DIGITS;

   logic [NUM_DIGITS-1:0] dec_en;
   logic [NUM_DIGITS-1:0] is_zero;
   logic [W-1:0]          ld_val;
   logic                  ld_force;

   assign zero = &is_zero;
   assign tc   = zero & enable & ~load;

`ifdef BCD_DOWN_AUTO_RELOAD_EN
   logic [W-1:0] clamped;
   logic [W-1:0] reload_q, reload_d;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_clamp
      assign clamped[BCD_W*i +: BCD_W] =
         bcd_clamp(load_value[BCD_W*i +: BCD_W]);
   end

   assign reload_d = load ? clamped : reload_q;

   always_ff @(posedge clock) begin
      if (clear_in)
         reload_q <= '0;
      else
         reload_q <= reload_d;
   end

   // Terminal count turns into a forced load of the reload value
   assign ld_force = load | tc;
   assign ld_val   = load ? load_value : reload_q;
`else
   assign ld_force = load;
   assign ld_val   = load_value;
`endif

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      if (i == 0) begin : g_lsd
         assign dec_en[i] = enable;
      end else begin : g_upper
         assign dec_en[i] = dec_en[i-1] & is_zero[i-1];
      end

      bcd_down_digit u_digit (
         .clock    (clock),
         .clear_in (clear_in),
         .load     (ld_force),
         .ld_val   (ld_val[BCD_W*i +: BCD_W]),
         .dec_en   (dec_en[i]),
         .q        (count[BCD_W*i +: BCD_W]),
         .is_zero  (is_zero[i])
      );
   end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Randomized self-checking bench for bcd_down_counter against
// a decimal integer model of the counter.
module tb_bcd_down_counter;

   localparam int ND   = 2;
   localparam int W    = 4 * ND;
   localparam int MAXV = 99;

   logic         clock = 1'b0;
   logic         clear_in = 1'b0;
   logic         enable = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_value = '0;
   logic [W-1:0] count;
   logic         zero;
   logic         tc;

   int tests = 0;
   int fails = 0;
   int m_val = 0;
   int m_reload = 0;

   bcd_down_counter #(.NUM_DIGITS(ND)) dut (
      .clock      (clock),
      .clear_in   (clear_in),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .zero       (zero),
      .tc         (tc)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int clamp_dec(input logic [W-1:0] v);
      int r;
      int d;
      r = 0;
      for (int i = ND - 1; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic bit exp_tc();
      return (m_val == 0) && enable && !load;
   endfunction

   task automatic drive(input logic c, input logic e,
                        input logic l, input logic [W-1:0] v);
      clear_in   = c;
      enable     = e;
      load       = l;
      load_value = v;
      #1;
   endtask

   task automatic edge_step();
      @(posedge clock);
      if (clear_in) begin
         m_val    = 0;
         m_reload = 0;
      end else if (load) begin
         m_val    = clamp_dec(load_value);
         m_reload = m_val;
      end else if (enable) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         m_val = (m_val == 0) ? m_reload : m_val - 1;
`else
         m_val = (m_val == 0) ? MAXV : m_val - 1;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b1, 1'b1, 8'h42);
      edge_step();
      drive(1'b0, 1'b1, 1'b0, '0);
      edge_step();
      drive(1'b1, 1'b1, 1'b0, '0);
      edge_step();
      drive(1'b0, 1'b0, 1'b0, '0);
      tests++;
      if (count !== 8'h00) begin
         fails++;
         $display("FAIL reset_count got=%h exp=00", count);
      end
      tests++;
      if (zero !== 1'b1) begin
         fails++;
         $display("FAIL reset_zero got=%b exp=1", zero);
      end
      tests++;
      if (tc !== 1'b0) begin
         fails++;
         $display("FAIL reset_tc_noen got=%b exp=0", tc);
      end
   endtask

   task automatic test_countdown();
      int ntc;
      ntc = 0;
      drive(1'b0, 1'b0, 1'b1, 8'h25);
      edge_step();
      tests++;
      if (count !== 8'h25) begin
         fails++;
         $display("FAIL cd_load got=%h exp=25", count);
      end
      for (int k = 0; k < 26; k++) begin
         drive(1'b0, 1'b1, 1'b0, '0);
         tests++;
         if (tc !== exp_tc()) begin
            fails++;
            $display("FAIL cd_tc step=%0d got=%b exp=%b", k, tc, exp_tc());
         end
         if (tc === 1'b1) ntc++;
         edge_step();
         tests++;
         if (count !== to_bcd(m_val)) begin
            fails++;
            $display("FAIL cd_count step=%0d got=%h exp=%h",
                     k, count, to_bcd(m_val));
         end
      end
      tests++;
      if (ntc != 1) begin
         fails++;
         $display("FAIL cd_tc_total got=%0d exp=1", ntc);
      end
   endtask

   task automatic test_borrow();
      drive(1'b0, 1'b0, 1'b1, 8'h10);
      edge_step();
      drive(1'b0, 1'b1, 1'b0, '0);
      edge_step();
      tests++;
      if (count !== 8'h09) begin
         fails++;
         $display("FAIL borrow got=%h exp=09", count);
      end
   endtask

   task automatic test_clamp();
      drive(1'b0, 1'b0, 1'b1, 8'hAF);
      edge_step();
      tests++;
      if (count !== 8'h99) begin
         fails++;
         $display("FAIL clamp got=%h exp=99", count);
      end
      drive(1'b0, 1'b1, 1'b1, 8'h37);
      tests++;
      if (tc !== 1'b0) begin
         fails++;
         $display("FAIL ld_en_tc got=%b exp=0", tc);
      end
      edge_step();
      tests++;
      if (count !== 8'h37) begin
         fails++;
         $display("FAIL ld_en_count got=%h exp=37", count);
      end
   endtask

   task automatic test_zero_boundary();
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      int ntc;
      logic [W-1:0] seq [8];
      seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
      ntc = 0;
      drive(1'b0, 1'b0, 1'b1, 8'h03);
      edge_step();
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b1, 1'b0, '0);
         if (tc === 1'b1) ntc++;
         edge_step();
         tests++;
         if (count !== seq[k]) begin
            fails++;
            $display("FAIL reload step=%0d got=%h exp=%h", k, count, seq[k]);
         end
      end
      tests++;
      if (ntc != 2) begin
         fails++;
         $display("FAIL reload_tc_total got=%0d exp=2", ntc);
      end
`else
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      edge_step();
      drive(1'b0, 1'b1, 1'b0, '0);
      tests++;
      if (tc !== 1'b1) begin
         fails++;
         $display("FAIL wrap_tc got=%b exp=1", tc);
      end
      edge_step();
      tests++;
      if (count !== 8'h99) begin
         fails++;
         $display("FAIL wrap_count got=%h exp=99", count);
      end
`endif
   endtask

   task automatic test_random();
      logic c, e, l;
      logic [W-1:0] v;
      for (int k = 0; k < 300; k++) begin
         c = ($urandom_range(0, 29) == 0);
         l = ($urandom_range(0, 6) == 0);
         e = ($urandom_range(0, 3) != 0);
         v = W'($urandom);
         drive(c, e, l, v);
         tests++;
         if (tc !== exp_tc() || zero !== (m_val == 0)) begin
            fails++;
            $display("FAIL rnd_comb k=%0d tc=%b/%b zero=%b/%b",
                     k, tc, exp_tc(), zero, (m_val == 0));
         end
         edge_step();
         tests++;
         if (count !== to_bcd(m_val)) begin
            fails++;
            $display("FAIL rnd_count k=%0d got=%h exp=%h",
                     k, count, to_bcd(m_val));
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0);
      edge_step();
      test_reset();
      test_countdown();
      test_borrow();
      test_clamp();
      test_zero_boundary();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
